// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Sequences the multi-cycle multiplier and divider for the main control unit.
// A one-cycle start request launches the selected unit with an init pulse.
// The sequencer then waits for that unit's stop, loads HI/LO from the matching
// source and pulses done. A divide-by-zero or a stalled unit (watchdog expiry)
// is reported as a one-cycle exception instead, and HI/LO are left untouched.
//
// Parameters:
//   TIMEOUT_CYCLES - WAIT cycles allowed before a timeout exception (2..255)
//   CNT_W          - wait counter width, must be able to hold TIMEOUT_CYCLES
//
// Ports:
//   clk          system clock, rising edge
//   reset_in     asynchronous, active-high reset
//   start_mult   one-cycle request: begin MULT
//   start_div    one-cycle request: begin DIV
//   mult_stop    multiplier result valid
//   div_stop     divider result valid
//   div_zero     divider reports zero divisor (qualified by div_stop)
//   mult_init    one-cycle start pulse to the multiplier
//   div_init     one-cycle start pulse to the divider
//   high_load    HI register load enable
//   low_load     LO register load enable
//   mux_high     HI source select (0 = multiplier, 1 = divider)
//   mux_low      LO source select (0 = multiplier, 1 = divider)
//   busy         sequencer not idle; control unit must stall
//   done         one-cycle pulse, HI/LO written
//   exc          one-cycle exception pulse
//   exc_cause    valid with exc: 01 = divide by zero, 10 = timeout
//   last_latency (MD_LATENCY_STAT_EN only) WAIT-cycle count of the last
//                operation that reached the HI/LO write
//
// Build option:
//   MD_LATENCY_STAT_EN - adds the last_latency output and its capture register
//
// Every output is decoded from registered state only; none depends
// combinationally on an input.
// ---------------------------------------------------------------------------
module md_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic             mult_stop,
   input  logic             div_stop,
   input  logic             div_zero,
   output logic             mult_init,
   output logic             div_init,
   output logic             high_load,
   output logic             low_load,
   output logic             mux_high,
   output logic             mux_low,
   output logic             busy,
   output logic             done,
   output logic             exc,
`ifdef MD_LATENCY_STAT_EN
   output logic [1:0]       exc_cause,
   output logic [CNT_W-1:0] last_latency
`else
   output logic [1:0]       exc_cause
`endif
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_M_INIT = 3'd1;
   localparam logic [2:0] ST_M_WAIT = 3'd2;
   localparam logic [2:0] ST_D_INIT = 3'd3;
   localparam logic [2:0] ST_D_WAIT = 3'd4;
   localparam logic [2:0] ST_WRITE  = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;
   localparam logic [2:0] ST_EXC    = 3'd7;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_DIVZ = 2'b01;
   localparam logic [1:0] CAUSE_TMO  = 2'b10;

   // Counter value of the last permitted WAIT cycle.
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic             op_div;
   logic             op_div_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [1:0]       cause_q;
   logic [1:0]       cause_nxt;
   logic             write_enter;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      op_div_nxt  = op_div;
      cnt_nxt     = cnt;
      cause_nxt   = cause_q;
      write_enter = 1'b0;

      case (state)
         ST_IDLE: begin
            // MULT has priority when both requests arrive together.
            if (start_mult) begin
               state_nxt  = ST_M_INIT;
               op_div_nxt = 1'b0;
            end else if (start_div) begin
               state_nxt  = ST_D_INIT;
               op_div_nxt = 1'b1;
            end
         end

         ST_M_INIT: begin
            state_nxt = ST_M_WAIT;
            cnt_nxt   = '0;
         end

         ST_D_INIT: begin
            state_nxt = ST_D_WAIT;
            cnt_nxt   = '0;
         end

         ST_M_WAIT: begin
            // A stop on the watchdog's last cycle still completes normally.
            if (mult_stop) begin
               state_nxt   = ST_WRITE;
               write_enter = 1'b1;
            end else if (cnt == CNT_LIMIT) begin
               state_nxt = ST_EXC;
               cause_nxt = CAUSE_TMO;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         ST_D_WAIT: begin
            // div_zero carries meaning only alongside div_stop.
            if (div_stop && div_zero) begin
               state_nxt = ST_EXC;
               cause_nxt = CAUSE_DIVZ;
            end else if (div_stop) begin
               state_nxt   = ST_WRITE;
               write_enter = 1'b1;
            end else if (cnt == CNT_LIMIT) begin
               state_nxt = ST_EXC;
               cause_nxt = CAUSE_TMO;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         ST_WRITE: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         ST_EXC:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state   <= ST_IDLE;
         op_div  <= 1'b0;
         cnt     <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         state   <= state_nxt;
         op_div  <= op_div_nxt;
         cnt     <= cnt_nxt;
         cause_q <= cause_nxt;
      end
   end

`ifdef MD_LATENCY_STAT_EN
   // Counter starts at 0 in the first WAIT cycle, so the cycle count is cnt+1.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         last_latency <= '0;
      end else if (write_enter) begin
         last_latency <= cnt + CNT_W'(1);
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Moore output decode
   // ------------------------------------------------------------------------
   always_comb begin
      mult_init = (state == ST_M_INIT);
      div_init  = (state == ST_D_INIT);
      high_load = (state == ST_WRITE);
      low_load  = (state == ST_WRITE);
      busy      = (state != ST_IDLE);
      // Source selects follow the operation in every non-idle state.
      mux_high  = (state != ST_IDLE) && op_div;
      mux_low   = (state != ST_IDLE) && op_div;
      done      = (state == ST_DONE);
      exc       = (state == ST_EXC);
      exc_cause = (state == ST_EXC) ? cause_q : CAUSE_NONE;
   end

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//
// Directed bench for md_sequencer with TIMEOUT_CYCLES = 8. A transaction-level
// model schedules the expected output word for each cycle from the request,
// stop and watchdog rules; a compare process checks every cycle against it.
// Literal expectations at key cycles pin the model itself.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

   localparam int TOUT = 8;

   typedef struct packed {
      logic       mi;
      logic       di;
      logic       hl;
      logic       ll;
      logic       mh;
      logic       ml;
      logic       bz;
      logic       dn;
      logic       ex;
      logic [1:0] ca;
   } ow_t;

   logic       clk = 1'b0;
   logic       reset_in = 1'b1;
   logic       start_mult = 1'b0;
   logic       start_div = 1'b0;
   logic       mult_stop = 1'b0;
   logic       div_stop = 1'b0;
   logic       div_zero = 1'b0;
   logic       mult_init, div_init, high_load, low_load;
   logic       mux_high, mux_low, busy, done, exc;
   logic [1:0] exc_cause;
`ifdef MD_LATENCY_STAT_EN
   logic [7:0] last_latency;
   logic [7:0] m_lat = '0;
`endif

   md_sequencer #(
      .TIMEOUT_CYCLES(TOUT),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .reset_in(reset_in),
      .start_mult(start_mult),
      .start_div(start_div),
      .mult_stop(mult_stop),
      .div_stop(div_stop),
      .div_zero(div_zero),
      .mult_init(mult_init),
      .div_init(div_init),
      .high_load(high_load),
      .low_load(low_load),
      .mux_high(mux_high),
      .mux_low(mux_low),
      .busy(busy),
      .done(done),
      .exc(exc),
`ifdef MD_LATENCY_STAT_EN
      .exc_cause(exc_cause),
      .last_latency(last_latency)
`else
      .exc_cause(exc_cause)
`endif
   );

   always #5 clk = ~clk;

   ow_t dut_w;
   assign dut_w = {mult_init, div_init, high_load, low_load, mux_high, mux_low,
                   busy, done, exc, exc_cause};

   int checks = 0;
   int errors = 0;

   // ------------------------------------------------------------------------
   // Transaction-level model
   // ------------------------------------------------------------------------
   ow_t cur = '0;
   ow_t q[$];
   bit  waiting = 0;
   bit  in_wait = 0;
   bit  opdiv = 0;
   int  wcnt = 0;

   function automatic ow_t w_mk(logic mi, logic di, logic hl, logic dn, logic ex,
                                logic op, logic [1:0] ca);
      ow_t w;
      w    = '0;
      w.mi = mi;
      w.di = di;
      w.hl = hl;
      w.ll = hl;
      w.mh = op;
      w.ml = op;
      w.bz = 1'b1;
      w.dn = dn;
      w.ex = ex;
      w.ca = ca;
      return w;
   endfunction

   initial forever begin
      bit was_idle;
      @(posedge clk or posedge reset_in);
      if (reset_in) begin
         q.delete();
         waiting = 0;
         in_wait = 0;
         cur     = '0;
`ifdef MD_LATENCY_STAT_EN
         m_lat   = '0;
`endif
      end else begin
         was_idle = !cur.bz;
         if (in_wait) begin
            in_wait = 0;
            wcnt++;
            if ((!opdiv && mult_stop) || (opdiv && div_stop && !div_zero)) begin
               waiting = 0;
               q.push_back(w_mk(0, 0, 1, 0, 0, opdiv, 2'b00));
               q.push_back(w_mk(0, 0, 0, 1, 0, opdiv, 2'b00));
`ifdef MD_LATENCY_STAT_EN
               m_lat = 8'(wcnt);
`endif
            end else if (opdiv && div_stop && div_zero) begin
               waiting = 0;
               q.push_back(w_mk(0, 0, 0, 0, 1, opdiv, 2'b01));
            end else if (wcnt == TOUT) begin
               waiting = 0;
               q.push_back(w_mk(0, 0, 0, 0, 1, opdiv, 2'b10));
            end
         end
         if (q.size() != 0) begin
            cur = q.pop_front();
         end else if (waiting) begin
            cur     = w_mk(0, 0, 0, 0, 0, opdiv, 2'b00);
            in_wait = 1;
         end else if (was_idle && start_mult) begin
            opdiv   = 0;
            waiting = 1;
            wcnt    = 0;
            cur     = w_mk(1, 0, 0, 0, 0, 1'b0, 2'b00);
         end else if (was_idle && start_div) begin
            opdiv   = 1;
            waiting = 1;
            wcnt    = 0;
            cur     = w_mk(0, 1, 0, 0, 0, 1'b1, 2'b00);
         end else begin
            cur = '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Per-cycle compare against the model
   // ------------------------------------------------------------------------
   initial forever begin
      @(negedge clk);
      checks++;
      if (dut_w !== cur) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t got=%b want=%b (mi di hl ll mh ml bz dn ex ca)",
                  $time, dut_w, cur);
      end
`ifdef MD_LATENCY_STAT_EN
      checks++;
      if (last_latency !== m_lat) begin
         errors++;
         $display("FAIL last_latency t=%0t got=%0d want=%0d", $time, last_latency, m_lat);
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   ow_t obs;
   int  n_mi, n_di, n_hl, n_dn, n_ex, n_wait;

   task automatic clr();
      n_mi = 0; n_di = 0; n_hl = 0; n_dn = 0; n_ex = 0; n_wait = 0;
   endtask

   // Observe the current cycle, then drive inputs sampled at its closing edge.
   task automatic step(input logic sm, input logic sd, input logic ms,
                       input logic ds, input logic dz);
      @(negedge clk);
      obs = dut_w;
      n_mi += int'(obs.mi);
      n_di += int'(obs.di);
      n_hl += int'(obs.hl);
      n_dn += int'(obs.dn);
      n_ex += int'(obs.ex);
      if (obs.bz && !obs.mi && !obs.di && !obs.hl && !obs.dn && !obs.ex) n_wait++;
      start_mult = sm;
      start_div  = sd;
      mult_stop  = ms;
      div_stop   = ds;
      div_zero   = dz;
   endtask

   task automatic lit(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, got, exp);
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   // ------------------------------------------------------------------------
   // Directed tests
   // ------------------------------------------------------------------------
   initial begin
      repeat (2) @(negedge clk);
      lit("reset_state", int'(dut_w), 0);
      #1 reset_in = 1'b0;

      // MULT, stop on 3rd WAIT cycle; start held from DONE into IDLE.
      clr();
      step(1, 0, 0, 0, 0);
      idle();               lit("t1_mult_init", int'(obs.mi), 1);
      lit("t1_busy_init", int'(obs.bz), 1);
      idle();
      idle();
      step(0, 0, 1, 0, 0);
      idle();               lit("t1_hl", int'(obs.hl), 1);
      lit("t1_ll", int'(obs.ll), 1);
      lit("t1_mux", int'({obs.mh, obs.ml}), 0);
      step(1, 0, 0, 0, 0);  lit("t1_done", int'(obs.dn), 1);
      step(1, 0, 0, 0, 0);  lit("t1_idle_gap", int'(obs.bz), 0);
      idle();               lit("t1_reaccept", int'(obs.mi), 1);
      idle();
      step(0, 0, 1, 0, 0);
      idle();
      idle();
      idle();
      lit("t1_done_cnt", n_dn, 2);

      // DIV, stop on 5th WAIT cycle; start only during DONE is dropped.
      clr();
      step(0, 1, 0, 0, 0);
      idle();               lit("t2_div_init", int'(obs.di), 1);
      repeat (4) idle();
      step(0, 0, 0, 1, 0);
      idle();               lit("t2_mux", int'({obs.mh, obs.ml}), 3);
      lit("t2_hl", int'(obs.hl), 1);
      step(0, 1, 0, 0, 0);  lit("t2_done", int'(obs.dn), 1);
      idle();
      idle();               lit("t2_idle", int'(obs.bz), 0);
      lit("t2_wait_cnt", n_wait, 5);
      lit("t2_div_cnt", n_di, 1);
      lit("t2_exc_cnt", n_ex, 0);

      // DIV by zero; stray div_zero and mult_stop ignored first.
      clr();
      step(0, 1, 0, 0, 0);
      idle();
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1);
      idle();               lit("t3_exc", int'(obs.ex), 1);
      lit("t3_cause", int'(obs.ca), 1);
      lit("t3_hl", int'(obs.hl), 0);
      idle();               lit("t3_idle", int'(obs.bz), 0);
      lit("t3_done_cnt", n_dn, 0);
      lit("t3_wait_cnt", n_wait, 3);

      // Timeout after exactly TOUT WAIT cycles.
      clr();
      step(1, 0, 0, 0, 0);
      idle();
      repeat (TOUT) idle();
      idle();               lit("t4_exc", int'(obs.ex), 1);
      lit("t4_cause", int'(obs.ca), 2);
      idle();
      lit("t4_wait_cnt", n_wait, TOUT);
      lit("t4_hl_cnt", n_hl, 0);

      // Stop on the last WAIT cycle wins over the watchdog.
      clr();
      step(1, 0, 0, 0, 0);
      idle();
      repeat (TOUT - 1) idle();
      step(0, 0, 1, 0, 0);
      idle();               lit("t4b_hl", int'(obs.hl), 1);
      idle();               lit("t4b_done", int'(obs.dn), 1);
      idle();
      lit("t4b_exc_cnt", n_ex, 0);
      lit("t4b_wait_cnt", n_wait, TOUT);

      // Simultaneous starts, then a DIV request during M_WAIT.
      clr();
      step(1, 1, 0, 0, 0);
      idle();               lit("t5_mult_init", int'(obs.mi), 1);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      idle();               lit("t5_mux", int'({obs.mh, obs.ml}), 0);
      idle();
      idle();
      idle();
      lit("t5_div_cnt", n_di, 0);
      lit("t5_mult_cnt", n_mi, 1);
      lit("t5_done_cnt", n_dn, 1);

      // Asynchronous reset mid-WAIT, stop afterwards, then a normal DIV.
      clr();
      step(1, 0, 0, 0, 0);
      idle();
      idle();
      idle();
      @(posedge clk);
      #2;
      reset_in  = 1'b1;
      mult_stop = 1'b1;
      #1 lit("t6_async_zero", int'(dut_w), 0);
      @(negedge clk);
      #1 reset_in = 1'b0;
      clr();
      repeat (3) step(0, 0, 1, 0, 0);
      lit("t6_no_load", n_hl, 0);
      lit("t6_idle", int'(obs.bz), 0);
      step(0, 1, 0, 0, 0);
      idle();               lit("t6_div_init", int'(obs.di), 1);
      idle();
      step(0, 0, 0, 1, 0);
      idle();               lit("t6_mux", int'({obs.mh, obs.ml}), 3);
      idle();               lit("t6_done", int'(obs.dn), 1);
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
